// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-side responders: FSM encoding,
// word geometry and the address-legality check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;

  // An address is illegal if it is not word aligned or lies beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read, contents not reset.
module dmem_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // NOTE: storage arrays get no reset branch; resetting them would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: valid/ready request port, fixed access latency,
// one in-order response per request.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 0..15");
  end

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_t            r_state;
  logic [3:0]            r_cnt;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  r_write;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_req_err;
  logic                  w_enter_resp;
  logic                  w_acc_write;
  logic                  w_acc_err;
  logic [ADDR_WIDTH-1:0] w_acc_idx;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_accept  = bus.req_valid & r_ready;
  assign w_req_err = addr_err(bus.req_addr, ADDR_WIDTH);

  // With zero latency the access happens on the accepting edge, so it uses the live request.
  assign w_enter_resp = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_acc_write  = (LATENCY == 0) ? bus.req_write                   : r_write;
  assign w_acc_err    = (LATENCY == 0) ? w_req_err                       : r_err;
  assign w_acc_idx    = (LATENCY == 0) ? bus.req_addr[ADDR_WIDTH+1:2]    : r_idx;
  assign w_acc_wdata  = (LATENCY == 0) ? bus.req_wdata                   : r_wdata;

  // Gated by reset_n so a request presented while reset is held can never commit.
  assign w_we = w_enter_resp & w_acc_write & ~w_acc_err & reset_n;

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  // NOTE: all state here updates with <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;

      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_write <= bus.req_write;
            r_err   <= w_req_err;
            r_idx   <= bus.req_addr[ADDR_WIDTH+1:2];
            r_wdata <= bus.req_wdata;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_acc_err;
        r_rdata      <= (w_acc_write || w_acc_err) ? '0 : w_ram_rdata;
      end
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.busy       = r_busy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for the main table,
// plus a LATENCY=0 instance for the zero-wait corner.
module tb_data_mem_responder;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  data_mem_responder_if #(.DATA_WIDTH(32)) m0 ();
  data_mem_responder_if #(.DATA_WIDTH(32)) m1 ();

  data_mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(2)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m0.slave)
  );

  data_mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(0)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the LATENCY=2 instance; the response must come 3 cycles after accept.
  task automatic txn0(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    n = 0;
    while (!m0.req_ready && n < 20) begin
      step();
      n++;
    end
    check($sformatf("%s ready", tag), 32'(m0.req_ready), 32'd1);
    m0.req_valid = 1'b1;
    m0.req_write = w;
    m0.req_addr  = a;
    m0.req_wdata = d;
    step();
    m0.req_valid = 1'b0;
    check($sformatf("%s busy", tag), 32'(m0.busy), 32'd1);
    check($sformatf("%s ready_low", tag), 32'(m0.req_ready), 32'd0);
    lat = 1;
    while (!m0.resp_valid && lat < 20) begin
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd3);
    check($sformatf("%s rdata", tag), m0.resp_rdata, exp_rd);
    check($sformatf("%s err", tag), 32'(m0.resp_err), 32'(exp_err));
    step();
    check($sformatf("%s pulse", tag), 32'(m0.resp_valid), 32'd0);
    check($sformatf("%s rdata_idle", tag), m0.resp_rdata, 32'd0);
    check($sformatf("%s err_idle", tag), 32'(m0.resp_err), 32'd0);
  endtask

  task automatic reset_mid_wait();
    m0.req_valid = 1'b1;
    m0.req_write = 1'b1;
    m0.req_addr  = 32'h10;
    m0.req_wdata = 32'hDEADBEEF;
    step();
    m0.req_valid = 1'b0;
    check("rst busy_before", 32'(m0.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst resp_valid", 32'(m0.resp_valid), 32'd0);
    check("rst ready", 32'(m0.req_ready), 32'd1);
    check("rst busy", 32'(m0.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst no_resp%0d", i), 32'(m0.resp_valid), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst quiet%0d", i), 32'(m0.resp_valid), 32'd0);
    end
  endtask

  // Four loads with req_valid held: accepts land on RESP cycles, responses 3 cycles apart.
  task automatic back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    int acc_i;
    int r_i;
    int cyc;
    int last_resp;
    logic acc;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C};
    exps  = '{32'h11111111, 32'h12345678, 32'h22222222, 32'h33333333};
    acc_i = 0;
    r_i = 0;
    cyc = 0;
    last_resp = -1;
    m0.req_valid = 1'b1;
    m0.req_write = 1'b0;
    m0.req_wdata = 32'h0;
    m0.req_addr  = addrs[0];
    while (r_i < 4 && cyc < 60) begin
      acc = m0.req_valid & m0.req_ready;
      if (acc && acc_i > 0) check($sformatf("b2b accept%0d in_resp", acc_i), 32'(m0.resp_valid), 32'd1);
      step();
      cyc++;
      if (acc) begin
        acc_i++;
        if (acc_i < 4) m0.req_addr = addrs[acc_i];
        else m0.req_valid = 1'b0;
      end
      if (m0.resp_valid) begin
        check($sformatf("b2b rdata%0d", r_i), m0.resp_rdata, exps[r_i]);
        check($sformatf("b2b err%0d", r_i), 32'(m0.resp_err), 32'd0);
        if (last_resp >= 0) check($sformatf("b2b spacing%0d", r_i), 32'(cyc - last_resp), 32'd3);
        last_resp = cyc;
        r_i++;
      end
    end
    m0.req_valid = 1'b0;
    check("b2b responses", 32'(r_i), 32'd4);
    step();
    check("b2b final_idle", 32'(m0.resp_valid), 32'd0);
  endtask

  // Zero-latency store then load held back-to-back; ready must stay high throughout.
  task automatic zero_latency();
    check("l0 ready_initial", 32'(m1.req_ready), 32'd1);
    m1.req_valid = 1'b1;
    m1.req_write = 1'b1;
    m1.req_addr  = 32'h3C;
    m1.req_wdata = 32'hCAFEF00D;
    step();
    check("l0 store resp_valid", 32'(m1.resp_valid), 32'd1);
    check("l0 store rdata", m1.resp_rdata, 32'd0);
    check("l0 store err", 32'(m1.resp_err), 32'd0);
    check("l0 ready1", 32'(m1.req_ready), 32'd1);
    check("l0 busy1", 32'(m1.busy), 32'd0);
    m1.req_write = 1'b0;
    m1.req_wdata = 32'h0;
    step();
    check("l0 load resp_valid", 32'(m1.resp_valid), 32'd1);
    check("l0 load rdata", m1.resp_rdata, 32'hCAFEF00D);
    check("l0 load err", 32'(m1.resp_err), 32'd0);
    check("l0 ready2", 32'(m1.req_ready), 32'd1);
    m1.req_valid = 1'b0;
    step();
    check("l0 idle resp_valid", 32'(m1.resp_valid), 32'd0);
    check("l0 idle rdata", m1.resp_rdata, 32'd0);
    check("l0 ready3", 32'(m1.req_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h12345678, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h00000000, 32'h12345678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h11111111, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'h22222222, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_000C, 32'h33333333, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0006, 32'h00000000, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0100, 32'hBADBAD00, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h00000000, 32'h11111111, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h00000000, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0100, 32'h00000000, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h00000000, 32'h11111111, 1'b0};

    reset_n = 1'b0;
    m0.req_valid = 1'b0; m0.req_write = 1'b0; m0.req_addr = 32'h0; m0.req_wdata = 32'h0;
    m1.req_valid = 1'b0; m1.req_write = 1'b0; m1.req_addr = 32'h0; m1.req_wdata = 32'h0;
    repeat (3) step();
    check("reset ready", 32'(m0.req_ready), 32'd1);
    check("reset resp_valid", 32'(m0.resp_valid), 32'd0);
    check("reset rdata", m0.resp_rdata, 32'd0);
    check("reset err", 32'(m0.resp_err), 32'd0);
    check("reset busy", 32'(m0.busy), 32'd0);
    check("reset l0 ready", 32'(m1.req_ready), 32'd1);
    reset_n = 1'b1;
    step();

    txn0("prewrite 0x10", 1'b1, 32'h10, 32'h0, 32'h0, 1'b0);
    reset_mid_wait();
    txn0("post-reset load 0x10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      txn0($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err);
    end

    back_to_back();
    zero_latency();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
